// File: rtl/router_fsm.sv
// -----------------------------------------------------------------------------
// router_fsm
//
// Packet-sequencing controller for the 1x3 router ingress path. It follows
// each packet from header decode through payload load to parity check. It
// drives the phase strobes used by the synchronizer and register blocks, and
// it stalls the source with `busy`.
//
// Optional feature, selected at compile time:
//   ROUTER_FSM_DROP_INVALID_EN
//     When this macro is defined, a header addressed to port 3 (which does
//     not exist) sends the FSM into DROP. The FSM leaves DROP only when
//     pkt_valid falls, so the whole packet is discarded. When the macro is
//     undefined, such a header is not consumed and the FSM stays in DA.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous, active-low reset
//   pkt_valid      in   source is presenting header/payload (low on parity)
//   din[1:0]       in   destination port field of the header byte
//   fifo_full      in   full flag of the currently addressed output FIFO
//   fifo_empty0..2 in   empty flags of output FIFOs 0..2
//   soft_reset0..2 in   per-port timeout strobes from the synchronizer
//   parity_done    in   register block has captured the parity byte
//   low_pkt_valid  in   register block saw pkt_valid fall with a byte held
//   detect_add     out  header decode phase (DA)
//   lfd_state      out  load-first-data phase (LFD)
//   ld_state       out  payload load phase (LD)
//   laf_state      out  load-after-full phase (LAF)
//   full_state     out  FIFO-full stall phase (FFS)
//   write_enb_reg  out  write request to the synchronizer (LD | LP | LAF)
//   rst_int_reg    out  parity-check phase (CPE)
//   busy           out  source must hold its current byte
// -----------------------------------------------------------------------------
module router_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] din,
  input  logic       fifo_full,
  input  logic       fifo_empty0,
  input  logic       fifo_empty1,
  input  logic       fifo_empty2,
  input  logic       soft_reset0,
  input  logic       soft_reset1,
  input  logic       soft_reset2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_DA   = 4'd0,  // decode address
    ST_LFD  = 4'd1,  // load first data (header)
    ST_LD   = 4'd2,  // load payload
    ST_FFS  = 4'd3,  // fifo full stall
    ST_LAF  = 4'd4,  // load after full
    ST_LP   = 4'd5,  // load parity
    ST_CPE  = 4'd6,  // check parity error
    ST_WTE  = 4'd7   // wait till empty
`ifdef ROUTER_FSM_DROP_INVALID_EN
    ,
    ST_DROP = 4'd8   // discard packet with invalid address
`endif
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  // The per-port flags are widened to four entries and entry 3 is tied low.
  // This lets any 2-bit address index the vectors safely. Address 3 is never
  // captured into addr_q, so entry 3 is only reached by din in DA, and in DA
  // that case is filtered out before the lookup.
  logic [3:0] fifo_empty_v;
  logic [3:0] soft_reset_v;

  assign fifo_empty_v = {1'b0, fifo_empty2, fifo_empty1, fifo_empty0};
  assign soft_reset_v = {1'b0, soft_reset2, soft_reset1, soft_reset0};

  // ---------------------------------------------------------------------------
  // State and address registers
  // ---------------------------------------------------------------------------
  // NOTE: reset is sampled only on the clock edge, so it is not in the
  // sensitivity list. Sequential state uses non-blocking assignments so that
  // every register updates from the values it had before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_DA;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default value first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    unique case (state_q)
      ST_DA: begin
        if (pkt_valid && din != 2'd3) begin
          addr_d  = din;
          state_d = fifo_empty_v[din] ? ST_LFD : ST_WTE;
        end
`ifdef ROUTER_FSM_DROP_INVALID_EN
        else if (pkt_valid) begin
          state_d = ST_DROP;
        end
`endif
      end

      ST_LFD: state_d = ST_LD;

      ST_LD: begin
        // A full FIFO must stall the stream before the end of the packet is
        // seen. For this reason fifo_full is tested before pkt_valid.
        if (fifo_full)       state_d = ST_FFS;
        else if (!pkt_valid) state_d = ST_LP;
      end

      ST_FFS: begin
        if (!fifo_full) state_d = ST_LAF;
      end

      ST_LAF: begin
        if (parity_done)        state_d = ST_DA;
        else if (low_pkt_valid) state_d = ST_LP;
        else                    state_d = ST_LD;
      end

      ST_LP: state_d = ST_CPE;

      ST_CPE: state_d = fifo_full ? ST_FFS : ST_DA;

      ST_WTE: begin
        if (fifo_empty_v[addr_q]) state_d = ST_LFD;
      end

`ifdef ROUTER_FSM_DROP_INVALID_EN
      ST_DROP: begin
        if (!pkt_valid) state_d = ST_DA;
      end
`endif

      default: state_d = ST_DA;
    endcase

    // A timeout on the addressed port overrides every other transition.
    // A timeout on any other port belongs to some other packet and is ignored.
    if (state_q != ST_DA && soft_reset_v[addr_q]) begin
      state_d = ST_DA;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode: outputs depend only on the registered state
  // ---------------------------------------------------------------------------
  assign detect_add    = (state_q == ST_DA);
  assign lfd_state     = (state_q == ST_LFD);
  assign ld_state      = (state_q == ST_LD);
  assign laf_state     = (state_q == ST_LAF);
  assign full_state    = (state_q == ST_FFS);
  assign write_enb_reg = (state_q == ST_LD) || (state_q == ST_LP) ||
                         (state_q == ST_LAF);
  assign rst_int_reg   = (state_q == ST_CPE);
  assign busy          = (state_q == ST_LFD) || (state_q == ST_FFS) ||
                         (state_q == ST_LAF) || (state_q == ST_LP)  ||
                         (state_q == ST_CPE) || (state_q == ST_WTE);

endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-sequencing controller for the 1x3 router ingress path. It tracks each packet from header through payload to parity and drives the write-enable request, address-detect and load-phase strobes consumed by the synchronizer and register blocks. It also stalls the source via `busy` while an output FIFO is full or still draining. One instance sits between the ingress port and the synchronizer/register pair.

## Interface
- No parameters. Port count is fixed at 3 (addresses 0..2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- pkt_valid  in  1  source asserts for header and payload bytes; deasserts on the parity byte.
- din  in  2  address field (bits [1:0]) of the header byte.
- fifo_full  in  1  full flag of the currently addressed FIFO, from the synchronizer.
- fifo_empty0/1/2  in  1  empty flags of output FIFOs 0..2.
- soft_reset0/1/2  in  1  per-port timeout strobes from the synchronizer.
- parity_done  in  1  register block has captured the parity byte.
- low_pkt_valid  in  1  register block saw pkt_valid fall while a byte was held.
- detect_add  out  1  header decode phase.
- lfd_state  out  1  load-first-data (header write) phase.
- ld_state  out  1  payload load phase.
- laf_state  out  1  load-after-full phase.
- full_state  out  1  FIFO-full stall phase.
- write_enb_reg  out  1  write request to the synchronizer.
- rst_int_reg  out  1  parity-check phase; clears internal register-block flags.
- busy  out  1  source must hold its current byte.

## Operation
- Moore FSM with states DA (decode address), LFD, LD, FFS (FIFO full), LAF, LP (load parity), CPE (check parity error) and WTE (wait till empty). An optional state, DROP, is described under Configuration.
- Internal 2-bit `addr` register captures `din` in DA when `pkt_valid` is high and `din != 3`.
- Transitions:
  - DA: `pkt_valid` and `din` in 0..2 -> LFD if `fifo_empty[din]`, else WTE. All other cases stay in DA.
  - LFD -> LD unconditionally.
  - LD: `fifo_full` -> FFS; else `!pkt_valid` -> LP; else stay in LD. `fifo_full` takes priority over `!pkt_valid`.
  - FFS: `!fifo_full` -> LAF; else stay in FFS.
  - LAF: `parity_done` -> DA; else `low_pkt_valid` -> LP; else -> LD.
  - LP -> CPE unconditionally.
  - CPE: `fifo_full` -> FFS; else -> DA.
  - WTE: `fifo_empty[addr]` -> LFD; else stay in WTE.
- Soft reset: if `soft_reset[addr]` is high in any state other than DA, the next state is DA. This has priority over every other transition. Soft resets of the non-addressed ports are ignored.
- Output decodes:
  - detect_add = DA
  - lfd_state = LFD
  - ld_state = LD
  - laf_state = LAF
  - full_state = FFS
  - write_enb_reg = LD | LP | LAF
  - rst_int_reg = CPE
  - busy = LFD | FFS | LAF | LP | CPE | WTE
- Reset (`rst = 0` at a clock edge): state DA and `addr = 0`. Resulting outputs: detect_add = 1, every other output = 0. Reset mid-packet aborts the packet, which is then lost.

## Timing
- All outputs are pure decodes of registered state, with no combinational path from inputs to outputs.
- A header accepted in DA at edge N puts the FSM in LFD (busy = 1) from N+1 and in LD (busy = 0, write_enb_reg = 1) from N+2.
- `fifo_full` sampled high in LD at edge N gives full_state = 1 from N+1.
- Last payload beat, then `pkt_valid` low in LD: LP for one cycle, then CPE for one cycle, then DA. Total is 2 cycles of busy.
- WTE has no timeout of its own; exit is only by `fifo_empty[addr]` or `soft_reset[addr]`.
- `din = 3` in DA: the header is not consumed and busy stays 0 (default build).

## Configuration
- `ROUTER_FSM_DROP_INVALID_EN` defined:
  - A header with `din = 3` and `pkt_valid = 1` in DA -> DROP.
  - DROP holds, with all outputs 0 except busy = 0, until `pkt_valid = 0`, then -> DA. The packet is silently discarded and write_enb_reg is never asserted.
- Not defined: DROP does not exist, and `din = 3` leaves the FSM in DA.

## Test plan
- Reset: hold `rst = 0` 2 cycles -> detect_add = 1, all other outputs 0; release with `pkt_valid = 0` -> stays in DA.
- Normal packet: header `din = 1`, `fifo_empty1 = 1`, 4 payload beats, then `pkt_valid = 0` -> sequence DA, LFD, LD×4, LP, CPE, DA; busy high exactly in LFD, LP and CPE.
- Full stall: `fifo_full` high 3 cycles mid-payload -> FFS ×3 then LAF; with `low_pkt_valid = 0` and `parity_done = 0` -> LD; with `parity_done = 1` -> DA.
- Busy port: header `din = 2`, `fifo_empty2 = 0` for 5 cycles -> WTE ×5, busy = 1; `fifo_empty2` rises -> LFD next cycle. Repeat with `soft_reset2` pulsed in WTE -> DA next cycle; pulse `soft_reset0` instead -> no effect.
- Invalid address: header `din = 3` -> default build stays in DA; with `ROUTER_FSM_DROP_INVALID_EN`, DROP until `pkt_valid` falls and write_enb_reg = 0 throughout.
- Mid-packet reset in LD -> DA on next edge, `addr = 0`, write_enb_reg = 0.
